// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
//   fw_width()    : width of a per-source forward select for a given stage count
//   FWD_RF        : forward-select code meaning "read the register file"
//   stall_state_t : load-use stall FSM states
package hazard_pkg;

    localparam int unsigned FWD_RF = 0;

    typedef enum logic {
        IDLE,
        STALL
    } stall_state_t;

    function automatic int unsigned fw_width(input int unsigned nstg);
        return $clog2(nstg + 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Pipeline-side bundle for hazard_fwd_unit.
//   i_ex_src/i_id_src/i_id_src_vld : execute and decode source operands
//   i_stg_rd/i_stg_we/i_stg_ld     : downstream producer stages (stage s at (s-1))
//   i_br_taken/i_freeze            : branch resolve and external pipeline hold
//   o_fwd_sel/o_fwd_err            : EX operand mux selects and not-ready flags
//   o_stall/o_bubble/o_flush       : IF/ID/EX enables
//   o_stall_cnt                    : saturating stall-cycle statistic
// master = pipeline side, slave = hazard unit.
interface hazard_fwd_unit_if
    import hazard_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned NSRC = 2,
    parameter int unsigned NSTG = 3,
    parameter int unsigned CW   = 16,
    parameter int unsigned FW   = fw_width(NSTG)
);
    logic [NSRC*AW-1:0] i_ex_src;
    logic [NSRC*AW-1:0] i_id_src;
    logic [NSRC-1:0]    i_id_src_vld;
    logic [NSTG*AW-1:0] i_stg_rd;
    logic [NSTG-1:0]    i_stg_we;
    logic [NSTG-1:0]    i_stg_ld;
    logic               i_br_taken;
    logic               i_freeze;
    logic [NSRC*FW-1:0] o_fwd_sel;
    logic [NSRC-1:0]    o_fwd_err;
    logic               o_stall;
    logic               o_bubble;
    logic               o_flush;
    logic [CW-1:0]      o_stall_cnt;

    modport master (
        output i_ex_src, i_id_src, i_id_src_vld, i_stg_rd, i_stg_we, i_stg_ld,
               i_br_taken, i_freeze,
        input  o_fwd_sel, o_fwd_err, o_stall, o_bubble, o_flush, o_stall_cnt
    );

    modport slave (
        input  i_ex_src, i_id_src, i_id_src_vld, i_stg_rd, i_stg_we, i_stg_ld,
               i_br_taken, i_freeze,
        output o_fwd_sel, o_fwd_err, o_stall, o_bubble, o_flush, o_stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_sel.sv
// Forward selector for one execute-stage source operand.
//   src    : source register address
//   stg_*  : destination/write-enable/pending-load vectors of the producer stages
//   sel    : winning stage number (nearest producer), FWD_RF when none
//   err    : winning producer is a load whose data is not yet available
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned NSTG = 3,
    parameter int unsigned FW   = fw_width(NSTG)
) (
    input  logic [AW-1:0]      src,
    input  logic [NSTG*AW-1:0] stg_rd,
    input  logic [NSTG-1:0]    stg_we,
    input  logic [NSTG-1:0]    stg_ld,
    output logic [FW-1:0]      sel,
    output logic               err
);
    // Scan oldest to nearest so the nearest match overwrites older ones.
    always_comb begin
        sel = FW'(FWD_RF);
        err = 1'b0;
        for (int unsigned s = NSTG; s >= 1; s--) begin
            if (stg_we[s-1] && (stg_rd[(s-1)*AW +: AW] != '0) &&
                (stg_rd[(s-1)*AW +: AW] == src)) begin
                sel = FW'(s);
                err = stg_ld[s-1];
            end
        end
    end
endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control for the in-order pipeline.
//   i_clk, i_rst_n : clock and asynchronous active-low reset
//   hz             : pipeline bundle (see hazard_fwd_unit_if)
// Forwarding and branch flush are combinational; load-use stalls run for
// LD_LAT unfrozen cycles from detection; stall cycles are counted with saturation.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned AW     = 5,
    parameter int unsigned NSRC   = 2,
    parameter int unsigned NSTG   = 3,
    parameter int unsigned LD_LAT = 1,
    parameter int unsigned CW     = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    hazard_fwd_unit_if.slave   hz
);
    localparam int unsigned FW   = fw_width(NSTG);
    localparam int unsigned CNTW = $clog2(LD_LAT + 1);

    logic [NSRC*FW-1:0] sel_raw;
    logic [NSRC-1:0]    err_raw;
    logic               haz;
    logic               stall_raw, bubble_raw, flush_raw;
    stall_state_t       state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]      stall_cnt_q;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        hazard_fwd_sel #(
            .AW   (AW),
            .NSTG (NSTG),
            .FW   (FW)
        ) u_sel (
            .src    (hz.i_ex_src[k*AW +: AW]),
            .stg_rd (hz.i_stg_rd),
            .stg_we (hz.i_stg_we),
            .stg_ld (hz.i_stg_ld),
            .sel    (sel_raw[k*FW +: FW]),
            .err    (err_raw[k])
        );
    end

    // Load in the nearest stage feeding any live decode source.
    always_comb begin
        haz = 1'b0;
        if (hz.i_stg_we[0] && hz.i_stg_ld[0] && (hz.i_stg_rd[AW-1:0] != '0)) begin
            for (int unsigned k = 0; k < NSRC; k++) begin
                if (hz.i_id_src_vld[k] && (hz.i_id_src[k*AW +: AW] == hz.i_stg_rd[AW-1:0]))
                    haz = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_raw  = 1'b0;
        bubble_raw = 1'b0;
        flush_raw  = 1'b0;
        if (hz.i_br_taken) begin
            flush_raw  = 1'b1;
            bubble_raw = 1'b1;
            cnt_d      = '0;
            state_d    = IDLE;
        end else if (state_q == STALL) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            if (!hz.i_freeze) begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1))
                    state_d = IDLE;
            end
        end else if (haz) begin
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
            // A frozen detect cycle does not count; the held pipeline re-presents
            // the hazard, so the load is taken on the first unfrozen detect.
            if ((LD_LAT > 1) && !hz.i_freeze) begin
                cnt_d   = CNTW'(LD_LAT - 1);
                state_d = STALL;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            stall_cnt_q <= '0;
        else if (stall_raw && !hz.i_freeze && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CW'(1);
    end

    // Control outputs are forced quiet while reset is held, independent of the clock.
    assign hz.o_fwd_sel   = i_rst_n ? sel_raw : '0;
    assign hz.o_fwd_err   = i_rst_n ? err_raw : '0;
    assign hz.o_stall     = i_rst_n & stall_raw;
    assign hz.o_bubble    = i_rst_n & bubble_raw;
    assign hz.o_flush     = i_rst_n & flush_raw;
    assign hz.o_stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_fwd_unit.sv
module tb_hazard_fwd_unit;
    logic clk = 1'b0;
    logic rst_n;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned stall_cycles;

    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.AW(5), .NSRC(2), .NSTG(3), .CW(16)) bus_a ();
    hazard_fwd_unit_if #(.AW(5), .NSRC(2), .NSTG(3), .CW(4))  bus_b ();

    hazard_fwd_unit #(.AW(5), .NSRC(2), .NSTG(3), .LD_LAT(2), .CW(16)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hz      (bus_a)
    );

    hazard_fwd_unit #(.AW(5), .NSRC(2), .NSTG(3), .LD_LAT(3), .CW(4)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .hz      (bus_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        bus_a.i_ex_src = '0; bus_a.i_id_src = '0; bus_a.i_id_src_vld = '0;
        bus_a.i_stg_rd = '0; bus_a.i_stg_we = '0; bus_a.i_stg_ld = '0;
        bus_a.i_br_taken = 1'b0; bus_a.i_freeze = 1'b0;
    endtask

    task automatic clear_b();
        bus_b.i_ex_src = '0; bus_b.i_id_src = '0; bus_b.i_id_src_vld = '0;
        bus_b.i_stg_rd = '0; bus_b.i_stg_we = '0; bus_b.i_stg_ld = '0;
        bus_b.i_br_taken = 1'b0; bus_b.i_freeze = 1'b0;
    endtask

    // Stage-1 load to r7 with decode source 0 reading r7.
    task automatic haz_b();
        bus_b.i_stg_rd = {5'd0, 5'd0, 5'd7};
        bus_b.i_stg_we = 3'b001; bus_b.i_stg_ld = 3'b001;
        bus_b.i_id_src = {5'd0, 5'd7}; bus_b.i_id_src_vld = 2'b01;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_a();
        clear_b();
        // Reset: every control output gated even with hazard, branch and match present.
        bus_a.i_ex_src = {5'd0, 5'd5};
        bus_a.i_stg_rd = {5'd0, 5'd0, 5'd5};
        bus_a.i_stg_we = 3'b001; bus_a.i_stg_ld = 3'b001;
        bus_a.i_id_src = {5'd0, 5'd5}; bus_a.i_id_src_vld = 2'b01;
        bus_a.i_br_taken = 1'b1;
        #1;
        chk("rst_stall",   bus_a.o_stall, 0);
        chk("rst_bubble",  bus_a.o_bubble, 0);
        chk("rst_flush",   bus_a.o_flush, 0);
        chk("rst_fwd_sel", bus_a.o_fwd_sel, 0);
        chk("rst_fwd_err", bus_a.o_fwd_err, 0);
        chk("rst_cnt",     bus_a.o_stall_cnt, 0);
        clear_a();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Forwarding priority.
        bus_a.i_ex_src = {5'd0, 5'd5};
        bus_a.i_stg_rd = {5'd5, 5'd9, 5'd5};
        bus_a.i_stg_we = 3'b101;
        #1;
        chk("fwd_s1_over_s3", bus_a.o_fwd_sel[1:0], 1);
        bus_a.i_stg_we = 3'b100;
        #1;
        chk("fwd_s3_only", bus_a.o_fwd_sel[1:0], 3);
        bus_a.i_stg_ld = 3'b100;
        #1;
        chk("fwd_err_s3_load", bus_a.o_fwd_err, 2'b01);
        bus_a.i_stg_rd = {5'd5, 5'd5, 5'd9};
        bus_a.i_stg_we = 3'b111;
        #1;
        chk("fwd_s2_over_s3", bus_a.o_fwd_sel[1:0], 2);
        chk("fwd_err_s2_noload", bus_a.o_fwd_err, 0);

        // Zero register never forwards, and a load to r0 is no hazard.
        bus_a.i_ex_src = {5'd0, 5'd5};
        bus_a.i_stg_rd = '0;
        bus_a.i_stg_we = 3'b111; bus_a.i_stg_ld = 3'b111;
        bus_a.i_id_src = '0; bus_a.i_id_src_vld = 2'b11;
        #1;
        chk("zero_sel1", bus_a.o_fwd_sel[3:2], 0);
        chk("zero_err",  bus_a.o_fwd_err, 0);
        chk("zero_nohaz", bus_a.o_stall, 0);
        clear_a();

        // Load-use, LD_LAT=2.
        bus_a.i_stg_rd = {5'd0, 5'd0, 5'd7};
        bus_a.i_stg_we = 3'b001; bus_a.i_stg_ld = 3'b001;
        bus_a.i_id_src = {5'd0, 5'd7}; bus_a.i_id_src_vld = 2'b00;
        #1;
        chk("lu_novld_stall", bus_a.o_stall, 0);
        bus_a.i_id_src_vld = 2'b01;
        #1;
        chk("lu_c0_stall",  bus_a.o_stall, 1);
        chk("lu_c0_bubble", bus_a.o_bubble, 1);
        chk("lu_c0_flush",  bus_a.o_flush, 0);
        step();
        clear_a();
        #1;
        chk("lu_c1_stall", bus_a.o_stall, 1);
        step();
        chk("lu_c2_stall", bus_a.o_stall, 0);
        chk("lu_cnt", bus_a.o_stall_cnt, 2);

        // Freeze mid-stall, LD_LAT=3: 3 unfrozen + 4 frozen cycles.
        stall_cycles = 0;
        haz_b();
        for (int unsigned i = 0; i < 12; i++) begin
            bus_b.i_freeze = (i >= 2 && i <= 5);
            #1;
            if (i == 3) chk("frz_bubble", bus_b.o_bubble, 1);
            if (bus_b.o_stall) stall_cycles++;
            step();
            clear_b();
        end
        chk("frz_len", stall_cycles, 7);
        chk("frz_cnt", bus_b.o_stall_cnt, 3);

        // Branch beats a simultaneous hazard.
        haz_b();
        bus_b.i_br_taken = 1'b1;
        #1;
        chk("br_haz_flush", bus_b.o_flush, 1);
        chk("br_haz_stall", bus_b.o_stall, 0);
        chk("br_haz_bubble", bus_b.o_bubble, 1);
        step();
        clear_b();
        #1;
        chk("br_haz_after", bus_b.o_stall, 0);

        // Branch in the second cycle of a LD_LAT=3 stall.
        haz_b();
        #1;
        chk("br_mid_c0", bus_b.o_stall, 1);
        step();
        clear_b();
        bus_b.i_br_taken = 1'b1;
        #1;
        chk("br_mid_c1_stall", bus_b.o_stall, 0);
        chk("br_mid_c1_flush", bus_b.o_flush, 1);
        step();
        clear_b();
        #1;
        chk("br_mid_c2_stall", bus_b.o_stall, 0);
        chk("br_mid_cnt", bus_b.o_stall_cnt, 4);

        // Asynchronous reset in the middle of a stall.
        bus_a.i_stg_rd = {5'd0, 5'd0, 5'd7};
        bus_a.i_stg_we = 3'b001; bus_a.i_stg_ld = 3'b001;
        bus_a.i_id_src = {5'd0, 5'd7}; bus_a.i_id_src_vld = 2'b01;
        step();
        clear_a();
        #1;
        chk("rstmid_pre", bus_a.o_stall, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall",  bus_a.o_stall, 0);
        chk("rstmid_bubble", bus_a.o_bubble, 0);
        chk("rstmid_cnt",    bus_a.o_stall_cnt, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rstrel_idle", bus_a.o_stall, 0);
        step();
        chk("rstrel_idle2", bus_a.o_stall, 0);

        // Saturation with CW=4: 20 consecutive stall cycles.
        chk("sat_start", bus_b.o_stall_cnt, 0);
        haz_b();
        for (int unsigned i = 0; i < 20; i++) step();
        chk("sat_cnt", bus_b.o_stall_cnt, 15);
        clear_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- **Forwarding:** for each execute-stage source operand, selects the youngest in-flight producer among `NSTG` downstream stages.
- **Load-use stalls:** detects load-use hazards against the decode-stage instruction and stalls for `LD_LAT` cycles, tracked by a registered down-counter.
- **Branch flush:** generates flushes on taken branches.
- **Statistics:** keeps a saturating stall-cycle counter.

It sits beside the ID/EX pipeline registers and drives the EX operand muxes and the IF/ID/EX enables.

## Interface
Parameters:
- `AW`, 5, register address width
- `NSRC`, 2, source operands per instruction
- `NSTG`, 3, forwarding stages (1 = EX/MEM output, nearest; `NSTG` = oldest, WB)
- `LD_LAT`, 1, stall cycles per load-use hazard (≥1)
- `CW`, 16, stall statistics counter width

Ports:
- `i_clk` in 1: clock, one clock domain, rising edge
- `i_rst_n` in 1: reset, asynchronous assert, active-low
- `i_ex_src` in `NSRC*AW`: execute-stage source addresses; source k is at bits [k*AW +: AW]
- `i_id_src` in `NSRC*AW`: decode-stage source addresses
- `i_id_src_vld` in `NSRC`: decode source k is actually read
- `i_stg_rd` in `NSTG*AW`: destination address of stage s, at bits [(s-1)*AW +: AW]
- `i_stg_we` in `NSTG`: stage s writes the register file
- `i_stg_ld` in `NSTG`: stage s holds a load whose data is not yet available at that stage
- `i_br_taken` in 1: taken branch resolved in EX this cycle
- `i_freeze` in 1: external memory wait; the pipeline holds
- `o_fwd_sel` out `NSRC*FW`: per-source select, where `FW` = `$clog2(NSTG+1)`; 0 = register file, s = stage s
- `o_fwd_err` out `NSRC`: selected producer is a not-ready load (assertion aid)
- `o_stall` out 1: hold PC and IF/ID
- `o_bubble` out 1: insert a bubble into ID/EX
- `o_flush` out 1: squash IF/ID
- `o_stall_cnt` out `CW`: saturating count of stall cycles

## Operation
**Forwarding (combinational), per source k:**
- Stage s matches when `i_stg_we[s]` is set, `i_stg_rd[s]` is non-zero, and `i_stg_rd[s]` equals source k.
- The lowest matching s wins; `o_fwd_sel` = s. With no match, `o_fwd_sel` = 0.
- Address 0 never forwards.
- `o_fwd_err[k]` = `i_stg_ld[s]` of the winning stage.

**Load-use hazard (`haz`):**
- Set when stage 1 has `we` and `ld` set, a non-zero rd, and rd equals some `i_id_src[k]` with `i_id_src_vld[k]` set.

**Stall FSM** (counter `cnt`, width `$clog2(LD_LAT+1)`):
- **IDLE** (`cnt` = 0)
  - `haz` and no branch: `o_stall` = `o_bubble` = 1.
  - If `LD_LAT` > 1, load `cnt` ← `LD_LAT`-1 and go to **STALL**.
- **STALL** (`cnt` ≠ 0)
  - `o_stall` = `o_bubble` = 1.
  - `cnt` decrements per cycle unless `i_freeze` is set; return to IDLE at 0.
  - A `haz` seen during STALL does not reload `cnt`.

**Branch:**
- `i_br_taken` gives `o_flush` = 1 and `o_bubble` = 1 the same cycle, and forces `o_stall` = 0.
- It clears `cnt` to 0 (the stalled instruction is squashed).
- Branch beats stall on simultaneous events.

**Freeze:**
- `i_freeze` does not alter any combinational output.
- It only pauses `cnt` and the statistics counter.

**Statistics:**
- `o_stall_cnt` increments on each cycle with `o_stall` = 1 and `i_freeze` = 0.
- It saturates at all-ones and does not wrap.

## Timing
- Forward selects, `haz`, and `o_flush` are combinational, with zero-cycle latency from the inputs.
- A stall lasts exactly `LD_LAT` unfrozen cycles, counted from the detect cycle inclusive.
- `cnt` and `o_stall_cnt` update on the rising edge of `i_clk`.
- **While `i_rst_n` is low:**
  - `cnt` = 0 and `o_stall_cnt` = 0.
  - `o_stall`, `o_bubble`, `o_flush`, and `o_fwd_err` are all 0 (gated).
  - `o_fwd_sel` = 0.
- **Reset mid-stall:** the state is lost and the first cycle after release is IDLE.
- **Reset release:** the first edge after deassertion behaves normally.

## Structure
- Package `hazard_pkg` holds:
  - the `FW` computation function
  - `FWD_RF` = 0
  - the stall FSM state enum (`IDLE`, `STALL`)
- Sub-module `hazard_fwd_sel` is instantiated `NSRC` times.
  - It contains one source address, the stage vectors, and a priority encoder.
  - Its outputs are `sel` and `err`.
- Stall FSM and statistics live in the top level.

## Test plan
- **Forward priority.** `NSTG`=3, `ex_src0`=5, with stages 1 and 3 both writing r5 (no load) → `o_fwd_sel[0]`=1. Drop stage 1 `we` → 3.
- **Zero register.** `ex_src1`=0, all stages write r0 → `o_fwd_sel[1]`=0 and `o_fwd_err`=0.
- **Load-use with `LD_LAT`=2.**
  - Stage 1 is a load to r7 and `id_src0`=7 is valid → `o_stall`/`o_bubble` high for exactly 2 cycles; `o_stall_cnt`=2.
  - Same case with `id_src_vld`=0 → no stall.
- **Freeze during stall.** `LD_LAT`=3, `i_freeze` high for 4 cycles in the middle of the stall → stall lasts 7 cycles; `o_stall_cnt`=3.
- **Branch vs stall.** `haz` and `i_br_taken` in the same cycle → `o_flush`=1, `o_stall`=0. Branch in cycle 2 of a `LD_LAT`=3 stall → `cnt` cleared; `o_stall` low the next cycle.
- **Reset and saturation.**
  - Assert `i_rst_n`=0 mid-stall → outputs 0 immediately, without a clock edge.
  - With `CW`=4, force 20 stall cycles → `o_stall_cnt`=15.
